// File: rtl/ppfifo_data_checker.sv
`default_nettype none
// ============================================================================
// Module      : ppfifo_data_checker
// Description : Drains blocks from the read side of a ping-pong FIFO and
//               keeps word/block counts and a running checksum. Defining
//               PPFIFO_CHECKER_PATTERN_EN adds an incrementing-pattern
//               checker with sticky error, saturating error count and
//               capture of the first mismatching word.
// Revision    : 1.0 - initial release
// ============================================================================
module ppfifo_data_checker #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic                  i_rd_rdy,
  output logic                  o_rd_act,
  input  logic [23:0]           i_rd_size,
  output logic                  o_rd_stb,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [31:0]           o_word_count,
  output logic [31:0]           o_block_count,
  output logic [DATA_WIDTH-1:0] o_checksum,
  output logic                  o_error,
  output logic [15:0]           o_error_count,
  output logic [DATA_WIDTH-1:0] o_first_error_data,
  output logic                  o_idle
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVATE = 2'd1,
    S_READ     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] size_q, size_d;
  logic [23:0] cnt_q, cnt_d;

  logic [31:0]           word_count_q;
  logic [31:0]           block_count_q;
  logic [DATA_WIDTH-1:0] checksum_q;

  // The FIFO is held only while a block is being consumed, so o_rd_act is
  // low in both RELEASE and IDLE and is guaranteed a gap between blocks.
  assign o_rd_act = (state_q == S_ACTIVATE) || (state_q == S_READ);
  assign o_rd_stb = (state_q == S_READ) && (cnt_q < size_q);
  assign o_idle   = (state_q == S_IDLE);

  // State, latched block size and in-block word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the last word's strobe moves straight to RELEASE so
  // the block is never over-read.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable && i_rd_rdy && !o_rd_act) state_d = S_ACTIVATE;
      end
      S_ACTIVATE: begin
        size_d  = i_rd_size;
        cnt_d   = '0;
        state_d = (i_rd_size == 24'd0) ? S_RELEASE : S_READ;
      end
      S_READ: begin
        if (cnt_q < size_q) begin
          cnt_d = cnt_q + 24'd1;
          if (cnt_q == size_q - 24'd1) state_d = S_RELEASE;
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Statistics; a clear takes priority over any word or block completing
  // in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count_q  <= '0;
      block_count_q <= '0;
      checksum_q    <= '0;
    end else if (i_clear) begin
      word_count_q  <= '0;
      block_count_q <= '0;
      checksum_q    <= '0;
    end else begin
      if (o_rd_stb) begin
        word_count_q <= word_count_q + 32'd1;
        checksum_q   <= checksum_q + i_rd_data;
      end
      if (state_q == S_RELEASE) block_count_q <= block_count_q + 32'd1;
    end
  end

  assign o_word_count  = word_count_q;
  assign o_block_count = block_count_q;
  assign o_checksum    = checksum_q;

`ifdef PPFIFO_CHECKER_PATTERN_EN
  logic [DATA_WIDTH-1:0] expected_q;
  logic                  error_q;
  logic [15:0]           error_count_q;
  logic [DATA_WIDTH-1:0] first_error_q;

  // Incrementing-pattern checker; only the first mismatch since the last
  // clear/reset is captured, later ones only bump the saturating count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      expected_q    <= '0;
      error_q       <= 1'b0;
      error_count_q <= '0;
      first_error_q <= '0;
    end else if (i_clear) begin
      expected_q    <= '0;
      error_q       <= 1'b0;
      error_count_q <= '0;
      first_error_q <= '0;
    end else if (o_rd_stb) begin
      expected_q <= expected_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      if (i_rd_data != expected_q) begin
        error_q <= 1'b1;
        if (error_count_q != 16'hFFFF) error_count_q <= error_count_q + 16'd1;
        if (!error_q) first_error_q <= i_rd_data;
      end
    end
  end

  assign o_error            = error_q;
  assign o_error_count      = error_count_q;
  assign o_first_error_data = first_error_q;
`else
  assign o_error            = 1'b0;
  assign o_error_count      = '0;
  assign o_first_error_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppfifo_data_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppfifo_data_checker
// Description : Directed self-checking bench for ppfifo_data_checker with a
//               simple ping-pong FIFO read-side model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppfifo_data_checker;

`ifdef PPFIFO_CHECKER_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic        i_clear;
  logic        i_rd_rdy;
  logic        o_rd_act;
  logic [23:0] i_rd_size;
  logic        o_rd_stb;
  logic [31:0] i_rd_data;
  logic [31:0] o_word_count;
  logic [31:0] o_block_count;
  logic [31:0] o_checksum;
  logic        o_error;
  logic [15:0] o_error_count;
  logic [31:0] o_first_error_data;
  logic        o_idle;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [64];
  int          rd_idx = 0;
  int          base;

  always #5 clk = ~clk;

  ppfifo_data_checker #(.DATA_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_enable           (i_enable),
    .i_clear            (i_clear),
    .i_rd_rdy           (i_rd_rdy),
    .o_rd_act           (o_rd_act),
    .i_rd_size          (i_rd_size),
    .o_rd_stb           (o_rd_stb),
    .i_rd_data          (i_rd_data),
    .o_word_count       (o_word_count),
    .o_block_count      (o_block_count),
    .o_checksum         (o_checksum),
    .o_error            (o_error),
    .o_error_count      (o_error_count),
    .o_first_error_data (o_first_error_data),
    .o_idle             (o_idle)
  );

  // FIFO model: presents the word at the read pointer, advances per strobe.
  assign i_rd_data = mem[rd_idx % 64];
  always @(posedge clk) begin
    if (rst && o_rd_stb) rd_idx <= rd_idx + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk) i_clear = 1'b1;
    @(negedge clk) i_clear = 1'b0;
  endtask

  task automatic wait_act();
    for (int k = 0; k < 50 && !o_rd_act; k++) @(negedge clk);
    check("act_seen", {31'd0, o_rd_act}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && !o_idle; k++) @(negedge clk);
    check("idle_seen", {31'd0, o_idle}, 32'd1);
  endtask

  task automatic wait_strobes(input int n);
    for (int k = 0; k < 100 && (rd_idx - base) < n; k++) @(negedge clk);
    check("strobes_seen", rd_idx - base, n);
  endtask

  // Offers one block of the given size and waits until it has been drained.
  task automatic run_block(input int size);
    base      = rd_idx;
    i_rd_size = size[23:0];
    i_rd_rdy  = 1'b1;
    @(negedge clk);
    wait_act();
    i_rd_rdy = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst = 1'b0; i_enable = 1'b0; i_clear = 1'b0; i_rd_rdy = 1'b0; i_rd_size = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    #1;
    check("rst_idle",   {31'd0, o_idle},   32'd1);
    check("rst_act",    {31'd0, o_rd_act}, 32'd0);
    check("rst_stb",    {31'd0, o_rd_stb}, 32'd0);
    check("rst_words",  o_word_count,      32'd0);
    check("rst_blocks", o_block_count,     32'd0);
    check("rst_csum",   o_checksum,        32'd0);
    check("rst_err",    {31'd0, o_error},  32'd0);
    @(negedge clk) rst = 1'b1;
    i_enable = 1'b1;

    // Size-4 block, data 0..3.
    for (int i = 0; i < 4; i++) mem[rd_idx + i] = i;
    run_block(4);
    check("b4_strobes", rd_idx - base,            32'd4);
    check("b4_words",   o_word_count,             32'd4);
    check("b4_blocks",  o_block_count,            32'd1);
    check("b4_csum",    o_checksum,               32'd6);
    check("b4_err",     {31'd0, o_error},         32'd0);
    check("b4_act",     {31'd0, o_rd_act},        32'd0);

    // Size-0 block after a clear.
    do_clear();
    check("clr_words",  o_word_count,  32'd0);
    check("clr_blocks", o_block_count, 32'd0);
    check("clr_csum",   o_checksum,    32'd0);
    run_block(0);
    check("b0_strobes", rd_idx - base,     32'd0);
    check("b0_blocks",  o_block_count,     32'd1);
    check("b0_words",   o_word_count,      32'd0);
    check("b0_idle",    {31'd0, o_idle},   32'd1);

    // Checksum wrap.
    do_clear();
    mem[rd_idx] = 32'hFFFF_FFFF; mem[rd_idx + 1] = 32'h2;
    run_block(2);
    check("wrap_csum",  o_checksum,   32'h1);
    check("wrap_words", o_word_count, 32'd2);

    // Pattern blocks 0,5,2 then 3,9,9.
    do_clear();
    mem[rd_idx] = 0; mem[rd_idx + 1] = 5; mem[rd_idx + 2] = 2;
    run_block(3);
    check("p1_csum",  o_checksum,                  32'd7);
    check("p1_err",   {31'd0, o_error},            PAT ? 32'd1 : 32'd0);
    check("p1_ecnt",  {16'd0, o_error_count},      PAT ? 32'd1 : 32'd0);
    check("p1_first", o_first_error_data,          PAT ? 32'd5 : 32'd0);
    mem[rd_idx] = 3; mem[rd_idx + 1] = 9; mem[rd_idx + 2] = 9;
    run_block(3);
    check("p2_csum",   o_checksum,                 32'd28);
    check("p2_words",  o_word_count,               32'd6);
    check("p2_blocks", o_block_count,              32'd2);
    check("p2_ecnt",   {16'd0, o_error_count},     PAT ? 32'd3 : 32'd0);
    check("p2_first",  o_first_error_data,         PAT ? 32'd5 : 32'd0);

    // Enable dropped after the 2nd strobe of a size-8 block; rdy held high.
    do_clear();
    for (int i = 0; i < 8; i++) mem[rd_idx + i] = i;
    base      = rd_idx;
    i_rd_size = 24'd8;
    i_rd_rdy  = 1'b1;
    @(negedge clk);
    wait_act();
    wait_strobes(2);
    i_enable = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
    check("en_strobes", rd_idx - base,     32'd8);
    check("en_words",   o_word_count,      32'd8);
    check("en_blocks",  o_block_count,     32'd1);
    check("en_csum",    o_checksum,        32'd28);
    check("en_noact",   {31'd0, o_rd_act}, 32'd0);
    check("en_err",     {31'd0, o_error},  32'd0);
    i_rd_rdy = 1'b0;
    i_enable = 1'b1;

    // Clear coincident with the 3rd strobe of a size-5 block.
    do_clear();
    for (int i = 0; i < 5; i++) mem[rd_idx + i] = i;
    base      = rd_idx;
    i_rd_size = 24'd5;
    i_rd_rdy  = 1'b1;
    @(negedge clk);
    wait_act();
    i_rd_rdy = 1'b0;
    wait_strobes(2);
    check("cl_stb3", {31'd0, o_rd_stb}, 32'd1);
    i_clear = 1'b1;
    @(negedge clk) i_clear = 1'b0;
    wait_idle();
    check("cl_strobes", rd_idx - base,             32'd5);
    check("cl_words",   o_word_count,              32'd2);
    check("cl_blocks",  o_block_count,             32'd1);
    check("cl_csum",    o_checksum,                32'd7);
    check("cl_ecnt",    {16'd0, o_error_count},    PAT ? 32'd2 : 32'd0);
    check("cl_first",   o_first_error_data,        PAT ? 32'd3 : 32'd0);

    // Asynchronous reset during the 2nd strobe of a block.
    for (int i = 0; i < 5; i++) mem[rd_idx + i] = 20 + i;
    base      = rd_idx;
    i_rd_rdy  = 1'b1;
    @(negedge clk);
    wait_act();
    i_rd_rdy = 1'b0;
    wait_strobes(1);
    rst = 1'b0;
    #1;
    check("ar_act",    {31'd0, o_rd_act},       32'd0);
    check("ar_stb",    {31'd0, o_rd_stb},       32'd0);
    check("ar_idle",   {31'd0, o_idle},         32'd1);
    check("ar_words",  o_word_count,            32'd0);
    check("ar_blocks", o_block_count,           32'd0);
    check("ar_csum",   o_checksum,              32'd0);
    check("ar_err",    {31'd0, o_error},        32'd0);
    check("ar_ecnt",   {16'd0, o_error_count},  32'd0);
    check("ar_first",  o_first_error_data,      32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_after_idle",   {31'd0, o_idle}, 32'd1);
    check("ar_after_blocks", o_block_count,   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
